// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader and any future image
// store/dump blocks that must agree on stream framing and byte order.
package program_loader_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

    // First byte on the stream lands in the least-significant byte of the word.
    localparam bit LITTLE_ENDIAN  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic logic is_stream_state(input state_t s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

    function automatic logic is_hold_state(input state_t s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_WRITE) ||
               (s == ST_CSUM) || (s == ST_ERR);
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Collects stream bytes into a 32-bit word; o_word_full flags the transfer
// that completes a word, with o_word_next holding the finished word.
module word_assembler
    import program_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word_next,
    output logic              o_word_full
);

    logic [WORD_W-1:0] r_shift;
    logic [1:0]        r_count;
    logic [WORD_W-1:0] w_shifted;

    generate
        if (LITTLE_ENDIAN) begin : g_le
            assign w_shifted = {i_byte, r_shift[WORD_W-1:BYTE_W]};
        end else begin : g_be
            assign w_shifted = {r_shift[WORD_W-BYTE_W-1:0], i_byte};
        end
    endgenerate

    assign o_word_next = w_shifted;
    assign o_word_full = i_valid && (r_count == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_valid) begin
            r_shift <= w_shifted;
            r_count <= r_count + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into memory while
// holding the processor in reset, then releases it with a start pulse.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_go,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [WORD_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    state_t            w_state_next;
    logic [BYTE_W-1:0] r_len;
    logic [BYTE_W-1:0] r_xor;
    logic [ADDR_W-1:0] r_index;
    logic [ADDR_W:0]   w_target;
    logic [ADDR_W:0]   w_words_inc;
    logic              w_xfer;
    logic              w_start;
    logic              w_data_xfer;
    logic [WORD_W-1:0] w_word_next;
    logic              w_word_full;

    assign w_xfer      = in_valid && in_ready;
    assign w_start     = load_go && ((r_state == ST_IDLE) || (r_state == ST_ERR));
    assign w_data_xfer = w_xfer && (r_state == ST_DATA);
    // A length byte of zero stands for a full memory image.
    assign w_target    = (r_len == '0) ? FULL_COUNT : (ADDR_W+1)'(r_len);
    assign w_words_inc = words_loaded + (ADDR_W+1)'(1);

    word_assembler u_word_assembler (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_start),
        .i_valid     (w_data_xfer),
        .i_byte      (in_data),
        .o_word_next (w_word_next),
        .o_word_full (w_word_full)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (load_go) w_state_next = ST_LEN;
            ST_LEN:   if (w_xfer) w_state_next = ST_DATA;
            ST_DATA:  if (w_xfer && w_word_full) w_state_next = ST_WRITE;
            ST_WRITE: w_state_next = (w_words_inc == w_target) ? ST_CSUM : ST_DATA;
            ST_CSUM:  if (w_xfer) w_state_next = (in_data == r_xor) ? ST_DONE : ST_ERR;
            ST_DONE:  w_state_next = ST_IDLE;
            ST_ERR:   if (load_go) w_state_next = ST_LEN;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_xor        <= '0;
            r_index      <= '0;
            in_ready     <= 1'b0;
            mem_address  <= '0;
            mem_data     <= '0;
            mem_wren     <= 1'b0;
            cpu_hold     <= 1'b0;
            cpu_start    <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            r_state   <= w_state_next;
            in_ready  <= is_stream_state(w_state_next);
            cpu_hold  <= is_hold_state(w_state_next);
            mem_wren  <= (w_state_next == ST_WRITE);
            done      <= (w_state_next == ST_DONE);
            cpu_start <= (w_state_next == ST_DONE);
            err       <= (w_state_next == ST_ERR);

            if (w_start) begin
                r_len        <= '0;
                r_xor        <= '0;
                r_index      <= '0;
                words_loaded <= '0;
            end

            case (r_state)
                ST_LEN: begin
                    if (w_xfer) begin
                        r_len <= in_data;
                        r_xor <= in_data;
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        r_xor <= r_xor ^ in_data;
                        if (w_word_full) begin
                            mem_data    <= w_word_next;
                            mem_address <= BASE + r_index;
                        end
                    end
                end
                ST_WRITE: begin
                    r_index      <= r_index + ADDR_W'(1);
                    words_loaded <= w_words_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader: builds byte streams from word lists and
// checks writes, handshake, pulses and error handling against a simple model.
module tb_program_loader;

    localparam int          ADDR_W = 8;
    localparam int          DEPTH  = 256;
    localparam int unsigned BASE   = 32'd254;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_go = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data;
    logic              mem_wren;
    logic              cpu_hold;
    logic              cpu_start;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    always #5 clk = ~clk;

    program_loader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_go      (load_go),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_wren     (mem_wren),
        .cpu_hold     (cpu_hold),
        .cpu_start    (cpu_start),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         wr_q[$];
    int          done_cnt = 0;
    int          start_cnt = 0;
    int          cyc = 0;
    logic [31:0] mem_obs[DEPTH];
    logic [31:0] mem_exp[DEPTH];
    logic [31:0] words[DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model samples the write port once per cycle; also watches pulse pairing.
    always @(negedge clk) begin
        if (mem_wren === 1'b1) begin
            wr_q.push_back('{mem_address, mem_data});
            mem_obs[mem_address] = mem_data;
        end
        if (done === 1'b1) done_cnt++;
        if (cpu_start === 1'b1) start_cnt++;
        if (done === 1'b1 || cpu_start === 1'b1) chk("done_with_start", 64'(cpu_start), 64'(done));
        if (cpu_hold === 1'b1 && err === 1'b0) chk("ready_low_only_in_write", 64'(in_ready), 64'(!mem_wren));
    end

    task automatic chk_zero(input string tag);
        chk({tag, ":in_ready"}, 64'(in_ready), 0);
        chk({tag, ":mem_address"}, 64'(mem_address), 0);
        chk({tag, ":mem_data"}, 64'(mem_data), 0);
        chk({tag, ":mem_wren"}, 64'(mem_wren), 0);
        chk({tag, ":cpu_hold"}, 64'(cpu_hold), 0);
        chk({tag, ":cpu_start"}, 64'(cpu_start), 0);
        chk({tag, ":done"}, 64'(done), 0);
        chk({tag, ":err"}, 64'(err), 0);
        chk({tag, ":words_loaded"}, 64'(words_loaded), 0);
    endtask

    // gap_mode: 0 none, 1 valid pattern 1,0,0,1, 2 random idle cycles.
    // busy_idx: byte index at which load_go is pulsed mid-load (-1 none).
    // stop_after: stop feeding before this byte index (-1 send whole stream).
    task automatic run_load(input int L, input bit bad, input int gap_mode,
                            input int busy_idx, input int stop_after, input string name);
        logic [7:0] q[$];
        logic [7:0] cs;
        logic [7:0] by;
        int nw;
        int t0;
        int k;
        int g;
        nw = (L == 0) ? DEPTH : L;
        q.push_back(8'(L));
        cs = 8'(L);
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < 4; b++) begin
                by = words[w][8*b +: 8];
                q.push_back(by);
                cs ^= by;
            end
        end
        q.push_back(bad ? (cs ^ 8'h01) : cs);

        wr_q.delete();
        done_cnt  = 0;
        start_cnt = 0;
        @(negedge clk);
        load_go = 1'b1;
        t0 = cyc;
        @(negedge clk);
        load_go = 1'b0;
        chk({name, ":err_cleared"}, 64'(err), 0);
        chk({name, ":hold_in_len"}, 64'(cpu_hold), 1);
        chk({name, ":ready_in_len"}, 64'(in_ready), 1);

        for (int i = 0; i < q.size(); i++) begin
            if (stop_after >= 0 && i == stop_after) return;
            g = (gap_mode == 1) ? ((i % 2 != 0) ? 2 : 0) :
                (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
            in_valid = 1'b0;
            repeat (g) @(negedge clk);
            in_valid = 1'b1;
            in_data  = q[i];
            if (i == busy_idx) load_go = 1'b1;
            k = 0;
            while (!in_ready && k < 100) begin
                @(negedge clk);
                load_go = 1'b0;
                k++;
            end
            if (k >= 100) begin
                chk({name, ":ready_timeout"}, 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            load_go = 1'b0;
        end
        in_valid = 1'b0;

        k = 0;
        while (!done && !err && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (bad) begin
            chk({name, ":err_set"}, 64'(err), 1);
            repeat (3) @(negedge clk);
            chk({name, ":err_sticky"}, 64'(err), 1);
            chk({name, ":hold_in_err"}, 64'(cpu_hold), 1);
            chk({name, ":ready_in_err"}, 64'(in_ready), 0);
            chk({name, ":no_start"}, 64'(start_cnt), 0);
            chk({name, ":no_done"}, 64'(done_cnt), 0);
        end else begin
            chk({name, ":done_seen"}, 64'(done), 1);
            if (gap_mode == 0 && busy_idx < 0)
                chk({name, ":latency"}, 64'(cyc - t0), 64'(5 * nw + 3));
            @(negedge clk);
            chk({name, ":done_one_cycle"}, 64'(done), 0);
            chk({name, ":hold_released"}, 64'(cpu_hold), 0);
            chk({name, ":done_count"}, 64'(done_cnt), 1);
            chk({name, ":start_count"}, 64'(start_cnt), 1);
            chk({name, ":err_clear"}, 64'(err), 0);
        end
        chk({name, ":words_loaded"}, 64'(words_loaded), 64'(nw));
        chk({name, ":write_count"}, 64'(wr_q.size()), 64'(nw));
        for (int i = 0; i < wr_q.size() && i < nw; i++) begin
            chk({name, ":addr"}, 64'(wr_q[i].a), 64'(8'(BASE + i)));
            chk({name, ":data"}, 64'(wr_q[i].d), 64'(words[i]));
        end
        for (int i = 0; i < nw; i++) mem_exp[8'(BASE + i)] = words[i];
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) words[i] = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int L;
        bit bad;
        for (int i = 0; i < DEPTH; i++) begin
            mem_obs[i] = '0;
            mem_exp[i] = '0;
            words[i]   = '0;
        end

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("in_reset");
        rst = 1'b0;
        @(negedge clk);
        chk_zero("after_reset");

        words[0] = 32'h1234_5678;
        words[1] = 32'hDEAD_BEEF;
        run_load(2, 1'b0, 0, -1, -1, "basic");
        run_load(2, 1'b1, 0, -1, -1, "bad_csum");
        run_load(2, 1'b0, 1, -1, -1, "gaps");

        fill_random(3);
        run_load(3, 1'b0, 0, 6, -1, "busy_go");

        for (int r = 0; r < 6; r++) begin
            L   = int'($urandom_range(1, 6));
            bad = ($urandom_range(0, 3) == 0);
            fill_random(L);
            run_load(L, bad, 2, -1, -1, "random");
        end

        fill_random(DEPTH);
        run_load(0, 1'b0, 0, -1, -1, "full_wrap");

        // Abort during the second word: only the first word may reach memory.
        fill_random(3);
        run_load(3, 1'b0, 0, -1, 7, "rst_mid");
        in_valid = 1'b0;
        chk("rst_mid:writes_before", 64'(wr_q.size()), 1);
        mem_exp[8'(BASE)] = words[0];
        rst = 1'b1;
        @(negedge clk);
        chk_zero("rst_mid");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_mid:no_writes_after", 64'(wr_q.size()), 1);
        chk("rst_mid:idle_hold", 64'(cpu_hold), 0);

        fill_random(2);
        run_load(2, 1'b0, 2, -1, -1, "after_rst");

        for (int a = 0; a < DEPTH; a++) chk("memory_image", 64'(mem_obs[a]), 64'(mem_exp[a]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
